// File: rtl/output_drain_o.sv
// Drains the RAM_O banks column-major onto a valid/ready stream.
// A 2-entry fall-through FIFO plus a read credit check absorbs stream backpressure.
module output_drain_o #(
    parameter int RAM_O_SIZE     = 1 << 8,
    parameter int ARRAY_M        = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(RAM_O_SIZE),
    parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M,
    parameter int DATA_SET_WIDTH = DATA_WIDTH * ARRAY_M
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(ARRAY_M):0]  num_cols,
    input  logic [ADDR_WIDTH:0]       num_rows,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic [ADDR_SET_WIDTH-1:0] rd_addr_set,
    output logic [ARRAY_M-1:0]        rd_enable_set,
    input  logic [DATA_SET_WIDTH-1:0] rd_data_set,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);
    localparam int CW = $clog2(ARRAY_M) + 1;
    localparam int RW = ADDR_WIDTH + 1;
    localparam int LW = $clog2(ARRAY_M);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cols_q, col, cols_clamp;
    logic [RW-1:0]          rows_q, row;
    logic [ADDR_WIDTH-1:0]  base_q, rd_addr;
    logic                   inflight, last_d;
    logic [LW-1:0]          col_d;
    logic [1:0][DATA_WIDTH-1:0] mem;
    logic [1:0]             tag;
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count;
    logic [2:0]             occ;
    logic                   pop, push, issue, last_issue;

    assign cols_clamp = (num_cols > CW'(ARRAY_M)) ? CW'(ARRAY_M) : num_cols;

    assign m_valid = (count != 2'd0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign m_last  = m_valid & tag[rd_ptr];
    assign pop     = m_valid & m_ready;
    assign push    = inflight;

    // Credit: words held plus the word in flight, less the one leaving now.
    assign occ        = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue      = (state == RUN) && (occ < 3'd2);
    assign last_issue = issue && (col == cols_q - CW'(1)) && (row == rows_q - RW'(1));

    assign rd_addr       = base_q + row[ADDR_WIDTH-1:0];
    assign rd_enable_set = issue ? (ARRAY_M'(1) << col) : '0;

    generate
        for (genvar m = 0; m < ARRAY_M; m++) begin : g_addr
            assign rd_addr_set[ADDR_WIDTH*m +: ADDR_WIDTH] = issue ? rd_addr : '0;
        end
    endgenerate

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (cols_clamp == '0 || num_rows == '0) ? DONE : RUN;
            RUN:   if (last_issue) state_nxt = FLUSH;
            // Leave once the final word is being popped and nothing is still returning.
            FLUSH: if (!inflight && count == {1'b0, pop}) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cols_q   <= '0;
            rows_q   <= '0;
            base_q   <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            last_d   <= 1'b0;
            col_d    <= '0;
            tag      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cols_q <= cols_clamp;
                rows_q <= num_rows;
                base_q <= base_addr;
                col    <= '0;
                row    <= '0;
            end
            if (issue) begin
                if (row == rows_q - RW'(1)) begin
                    row <= '0;
                    col <= col + CW'(1);
                end else begin
                    row <= row + RW'(1);
                end
            end
            inflight <= issue;
            col_d    <= col[LW-1:0];
            last_d   <= last_issue;
            if (push) begin
                mem[wr_ptr] <= rd_data_set[DATA_WIDTH*col_d +: DATA_WIDTH];
                tag[wr_ptr] <= last_d;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_output_drain_o.sv
// Directed bench for output_drain_o: bank RAM model, beat/done monitor, immediate-assert checks.
module tb_output_drain_o;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   num_cols = '0;
    logic [8:0]   num_rows = '0;
    logic [7:0]   base_addr = '0;
    logic [63:0]  rd_addr_set;
    logic [7:0]   rd_enable_set;
    logic [255:0] rd_data_set = '0;
    logic [31:0]  m_data;
    logic         m_valid, m_last, busy, done;
    logic         m_ready = 1'b1;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, t0 = 0;
    bit rand_rdy = 0;

    logic [31:0] beat_d[$];
    bit          beat_l[$];
    int          beat_c[$];
    int          done_c[$];
    int en_seen = 0, val_seen = 0, viol_out = 0, viol_stab = 0, viol_hot = 0;
    int issued = 0, popped = 0;
    logic pv = 0, pr = 0, pl = 0;
    logic [31:0] pd = '0;

    output_drain_o dut (
        .clk(clk), .reset(reset), .start(start), .num_cols(num_cols), .num_rows(num_rows),
        .base_addr(base_addr), .rd_addr_set(rd_addr_set), .rd_enable_set(rd_enable_set),
        .rd_data_set(rd_data_set), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank k word at address a holds (k<<16)|a; one-cycle read latency.
    always @(posedge clk)
        for (int k = 0; k < 8; k++)
            if (rd_enable_set[k]) rd_data_set[32*k +: 32] <= (32'(k) << 16) | 32'(rd_addr_set[8*k +: 8]);

    always @(posedge clk) begin
        #1;
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (reset) begin
            issued = 0; popped = 0; pv = 0;
        end else begin
            if (|rd_enable_set) begin issued++; en_seen++; end
            if ($countones(rd_enable_set) > 1) viol_hot++;
            if (m_valid) val_seen++;
            if (m_valid && m_ready) begin
                beat_d.push_back(m_data); beat_l.push_back(m_last); beat_c.push_back(cyc);
                popped++;
            end
            if (issued - popped > 2) viol_out++;
            if (pv && !pr && !(m_valid && m_data == pd && m_last == pl)) viol_stab++;
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            if (done) done_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int c, input int r, input int b);
        @(negedge clk);
        beat_d.delete(); beat_l.delete(); beat_c.delete(); done_c.delete();
        en_seen = 0; val_seen = 0;
        num_cols = 4'(c); num_rows = 9'(r); base_addr = 8'(b);
        start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_job(input string tag, input int cols, input int rows, input int base);
        int n, got;
        logic [31:0] e;
        repeat (3) @(negedge clk);
        n = cols * rows;
        got = beat_d.size();
        chk({tag, "_beats"}, 64'(got), 64'(n));
        for (int i = 0; i < n && i < got; i++) begin
            e = (32'(i / rows) << 16) | 32'((base + i % rows) & 255);
            chk({tag, "_data"}, 64'(beat_d[i]), 64'(e));
            chk({tag, "_last"}, 64'(beat_l[i]), 64'(i == n - 1));
        end
        chk({tag, "_done_cnt"}, 64'(done_c.size()), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_en", 64'(rd_enable_set), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        reset = 1'b0;

        // 8x4 full-rate job with timing checks
        go(8, 4, 0);
        chk("busy_c1", 64'(busy), 64'd1);
        chk("en_c1", 64'(rd_enable_set), 64'h01);
        wait_done(200);
        chk("done_cyc", 64'(cyc - t0), 64'd35);
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        check_job("j8x4", 8, 4, 0);
        if (beat_c.size() == 32) begin
            chk("first_beat_cyc", 64'(beat_c[0] - t0), 64'd3);
            chk("last_beat_cyc", 64'(beat_c[31] - t0), 64'd34);
        end else chk("beat_cyc_count", 64'(beat_c.size()), 64'd32);

        // address wrap
        go(1, 4, 8'hFE);
        wait_done(100);
        check_job("wrap", 1, 4, 8'hFE);

        // random backpressure
        rand_rdy = 1;
        go(8, 4, 0);
        wait_done(1000);
        rand_rdy = 0;
        check_job("rand", 8, 4, 0);

        // zero-size jobs
        go(8, 0, 0);
        wait_done(10);
        chk("zr_done_cyc", 64'(cyc - t0), 64'd1);
        check_job("zr", 8, 0, 0);
        chk("zr_en", 64'(en_seen), 64'd0);
        chk("zr_valid", 64'(val_seen), 64'd0);
        go(0, 4, 0);
        wait_done(10);
        chk("zc_done_cyc", 64'(cyc - t0), 64'd1);
        chk("zc_en", 64'(en_seen), 64'd0);
        chk("zc_valid", 64'(val_seen), 64'd0);

        // reset mid-job, then a fresh 2x2 job
        go(8, 4, 0);
        for (int i = 0; i < 200 && beat_d.size() < 10; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_en", 64'(rd_enable_set), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        go(2, 2, 0);
        wait_done(100);
        check_job("after_rst", 2, 2, 0);

        // start during RUN is ignored
        go(2, 3, 0);
        @(negedge clk);
        num_cols = 4'd1; num_rows = 9'd1; base_addr = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        check_job("restart", 2, 3, 0);

        // column count clamp
        go(12, 1, 0);
        wait_done(100);
        check_job("clamp", 8, 1, 0);

        chk("outstanding_viol", 64'(viol_out), 64'd0);
        chk("stable_viol", 64'(viol_stab), 64'd0);
        chk("onehot_viol", 64'(viol_hot), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
